// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states, counter width.
package mem_pkg;

  localparam int unsigned CntWidth = 4;

  // funct3 encodings of the load/store access size
  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store enables/data/error and load extraction with sign/zero extension.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        err_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Store path: lane enables, replicated write data, misalignment/unsupported-size error
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = '0;
    err_o   = 1'b0;
    case (size_i)
      SZ_B, SZ_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H, SZ_HU: begin
        err_o   = addr_lo_i[0];
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SZ_W: begin
        err_o   = (addr_lo_i != 2'b00);
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
      default: err_o = 1'b1;
    endcase
    // an erroring access must never touch memory
    if (err_o) be_o = 4'b0000;
  end

  // Load path: pick byte/halfword out of the raw word and extend it
  always_comb begin
    case (addr_lo_i)
      2'd0:    rbyte = rword_i[7:0];
      2'd1:    rbyte = rword_i[15:8];
      2'd2:    rbyte = rword_i[23:16];
      default: rbyte = rword_i[31:24];
    endcase
    rhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (size_i)
      SZ_B:    rdata_o = {{24{rbyte[7]}}, rbyte};
      SZ_BU:   rdata_o = {24'h0, rbyte};
      SZ_H:    rdata_o = {{16{rhalf[15]}}, rhalf};
      SZ_HU:   rdata_o = {16'h0, rhalf};
      SZ_W:    rdata_o = rword_i;
      default: rdata_o = '0;
    endcase
    if (err_o) rdata_o = '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states, byte-lane stores.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned Words = 2 ** (ADDR_WIDTH - 2);

  state_t                  state_q, state_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [2:0]              size_q, size_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;

  // Word array, little-endian lanes; not reset, externally preloadable.
  logic [31:0] mem [Words];

  logic        resp;
  logic        mem_we;
  logic [31:0] rword;
  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic        align_err;
  logic [31:0] ld_data;

  // high address bits are deliberately not decoded: addresses alias
  logic unused_addr;
  assign unused_addr = ^addr_i[31:ADDR_WIDTH];

  assign resp  = (state_q == BUSY) && (cnt_q == '0);
  assign rword = mem[addr_q[ADDR_WIDTH-1:2]];

  mem_align u_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rword_i   (rword),
    .be_o      (be),
    .wdata_o   (wdata_sh),
    .err_o     (align_err),
    .rdata_o   (ld_data)
  );

  // Outputs depend only on registered state and latched request
  always_comb begin
    req_ready_o = (state_q == IDLE);
    busy_o      = (state_q != IDLE);
    rvalid_o    = resp;
    err_o       = resp && align_err;
    rdata_o     = (resp && !we_q) ? ld_data : '0;
    mem_we      = resp && we_q && !align_err && !rst;
  end

  // Next state: accept in IDLE, count down wait states in BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = we_i;
          size_d  = size_i;
          addr_d  = addr_i[ADDR_WIDTH-1:0];
          wdata_d = wdata_i;
          cnt_d   = CntWidth'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, counter and request latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Store commits at the end of the response cycle, lane by lane
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule
